// File: rtl/dmem_map_pkg.sv
// Shared address-map constants and region decode for the data-memory responder.
package dmem_map_pkg;

  localparam logic [1:0] OFF_CYCLE  = 2'd0;
  localparam logic [1:0] OFF_LED    = 2'd1;
  localparam logic [1:0] OFF_CMP    = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam int ST_MATCH  = 0;
  localparam int ST_BUSERR = 1;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_MMIO = 2'd1,
    REG_NONE = 2'd2
  } region_e;

  // The MMIO window sits at the top of the map, so base + 3 never overflows.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input logic [31:0] depth,
                                            input logic [31:0] base);
    region_e r;
    r = REG_NONE;
    if (addr < depth) begin
      r = REG_RAM;
    end else if ((addr >= base) && ((addr - base) <= 32'd3)) begin
      r = REG_MMIO;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Processor data-memory port: word address, write data/enable, registered read data.
interface dmem_responder_if;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;

  modport master (output address_dmem, output data, output wren, input q_dmem);
  modport slave  (input address_dmem, input data, input wren, output q_dmem);
endinterface

// File: rtl/dmem_mmio_regs.sv
// MMIO register block: free-running cycle counter, LED register, compare timer and status.
module dmem_mmio_regs
  import dmem_map_pkg::*;
#(
  parameter int LED_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sel,
  input  logic             wren,
  input  logic [1:0]       offset,
  input  logic [31:0]      wdata,
  input  logic             bus_err_set,
  output logic [31:0]      rdata,
  output logic [LED_W-1:0] leds,
  output logic             timer_irq,
  output logic             bus_err
);

  logic [31:0]      cycle_q;
  logic [LED_W-1:0] led_q;
  logic [31:0]      cmp_q;
  logic             match_q;
  logic             buserr_q;

  logic wr_led;
  logic wr_cmp;
  logic wr_status;
  logic match_hit;

  assign wr_led    = sel && wren && (offset == OFF_LED);
  assign wr_cmp    = sel && wren && (offset == OFF_CMP);
  assign wr_status = sel && wren && (offset == OFF_STATUS);
  assign match_hit = (cycle_q == cmp_q);

  // Set terms are OR-ed after the clear so a coincident event always survives.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q  <= '0;
      led_q    <= '0;
      cmp_q    <= 32'hFFFF_FFFF;
      match_q  <= 1'b0;
      buserr_q <= 1'b0;
    end else begin
      cycle_q  <= cycle_q + 32'd1;
      if (wr_led) led_q <= wdata[LED_W-1:0];
      if (wr_cmp) cmp_q <= wdata;
      match_q  <= match_hit   | (match_q  & ~(wr_status & wdata[ST_MATCH]));
      buserr_q <= bus_err_set | (buserr_q & ~(wr_status & wdata[ST_BUSERR]));
    end
  end

  always_comb begin
    rdata = '0;
    unique case (offset)
      OFF_CYCLE:  rdata = cycle_q;
      OFF_LED:    rdata[LED_W-1:0] = led_q;
      OFF_CMP:    rdata = cmp_q;
      OFF_STATUS: begin
        rdata[ST_MATCH]  = match_q;
        rdata[ST_BUSERR] = buserr_q;
      end
      default:    rdata = '0;
    endcase
  end

  assign leds      = led_q;
  assign timer_irq = match_q;
  assign bus_err   = buserr_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus MMIO block behind a one-cycle registered read port.
module dmem_responder
  import dmem_map_pkg::*;
#(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FFF0,
  parameter int          LED_W     = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  dmem_responder_if.slave  bus,
  output logic [LED_W-1:0] leds,
  output logic             timer_irq,
  output logic             bus_err
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] ram [DEPTH];

  region_e       region;
  logic [AW-1:0] ram_idx;
  logic          ram_we;
  logic [31:0]   mmio_rdata;
  logic [31:0]   rd_next;
  logic [31:0]   q_q;

  assign region  = decode_region(bus.address_dmem, 32'(DEPTH), MMIO_BASE);
  assign ram_idx = bus.address_dmem[AW-1:0];
  // Gating with reset_n drops a write whose edge lands while reset is held.
  assign ram_we  = bus.wren && (region == REG_RAM) && reset_n;

  always_ff @(posedge clock) begin
    if (ram_we) ram[ram_idx] <= bus.data;
  end

  dmem_mmio_regs #(
    .LED_W(LED_W)
  ) u_regs (
    .clock       (clock),
    .reset_n     (reset_n),
    .sel         (region == REG_MMIO),
    .wren        (bus.wren),
    .offset      (bus.address_dmem[1:0]),
    .wdata       (bus.data),
    .bus_err_set (region == REG_NONE),
    .rdata       (mmio_rdata),
    .leds        (leds),
    .timer_irq   (timer_irq),
    .bus_err     (bus_err)
  );

  // RAM is read combinationally here so the registered output sees pre-write contents.
  always_comb begin
    rd_next = '0;
    unique case (region)
      REG_RAM:  rd_next = ram[ram_idx];
      REG_MMIO: rd_next = mmio_rdata;
      default:  rd_next = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= rd_next;
    end
  end

  assign bus.q_dmem = q_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: RAM, MMIO, timer, bus error and reset.
module tb_dmem_responder;
  import dmem_map_pkg::*;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] MMIO  = 32'hFFFF_FFF0;
  localparam int          LED_W = 16;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [LED_W-1:0] leds;
  logic             timer_irq;
  logic             bus_err;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH(DEPTH), .MMIO_BASE(MMIO), .LED_W(LED_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .leds      (leds),
    .timer_irq (timer_irq),
    .bus_err   (bus_err)
  );

  always #5 clock = ~clock;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] cnt      = 32'd0;
  logic [31:0] q;

  // Drive at a falling edge, let one rising edge pass, sample at the next falling edge.
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic we,
                        output logic [31:0] rq);
    bus.address_dmem = a;
    bus.data         = d;
    bus.wren         = we;
    @(posedge clock);
    @(negedge clock);
    rq  = bus.q_dmem;
    cnt = cnt + 32'd1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    bus.wren = 1'b0;
    bus.address_dmem = 32'd0;
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    cnt = 32'd0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.q_dmem !== 32'd0) begin failures++; $display("FAIL reset_q got=%h exp=0", bus.q_dmem); end
    checks++; if (leds !== 16'd0) begin failures++; $display("FAIL reset_leds got=%h exp=0", leds); end
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL reset_buserr got=%b exp=0", bus_err); end
    @(negedge clock);
    reset_n = 1'b1;
    cnt = 32'd0;
  endtask

  task automatic test_ram();
    access(32'd6, 32'd0, 1'b1, q);
    access(32'd5, 32'hDEAD_BEEF, 1'b1, q);
    access(32'd5, 32'd0, 1'b0, q);
    checks++; if (q !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_rt got=%h exp=deadbeef", q); end
    access(32'd6, 32'd0, 1'b0, q);
    checks++; if (q !== 32'd0) begin failures++; $display("FAIL ram_zero got=%h exp=0", q); end
    access(32'(DEPTH - 1), 32'hA5A5_5A5A, 1'b1, q);
    access(32'(DEPTH - 1), 32'd0, 1'b0, q);
    checks++; if (q !== 32'hA5A5_5A5A) begin failures++; $display("FAIL ram_top got=%h exp=a5a55a5a", q); end
  endtask

  task automatic test_rdw();
    access(32'd9, 32'h1, 1'b1, q);
    access(32'd9, 32'h2, 1'b1, q);
    checks++; if (q !== 32'h1) begin failures++; $display("FAIL rdw_old got=%h exp=1", q); end
    access(32'd9, 32'h0, 1'b0, q);
    checks++; if (q !== 32'h2) begin failures++; $display("FAIL rdw_new got=%h exp=2", q); end
  endtask

  task automatic test_led();
    access(MMIO + 32'd1, 32'h1234_ABCD, 1'b1, q);
    checks++; if (leds !== 16'hABCD) begin failures++; $display("FAIL led_out got=%h exp=abcd", leds); end
    access(MMIO + 32'd1, 32'd0, 1'b0, q);
    checks++; if (q !== 32'h0000_ABCD) begin failures++; $display("FAIL led_rd got=%h exp=0000abcd", q); end
  endtask

  task automatic test_cycle();
    do_reset();
    for (int i = 0; i < 9; i++) access(32'd0, 32'd0, 1'b0, q);
    access(MMIO, 32'd0, 1'b0, q);
    checks++; if (q !== 32'd9) begin failures++; $display("FAIL cycle_10th got=%h exp=9", q); end
    access(MMIO, 32'h5555_5555, 1'b1, q);
    access(MMIO, 32'd0, 1'b0, q);
    checks++; if (q !== 32'd11) begin failures++; $display("FAIL cycle_ro got=%h exp=b", q); end
    force dut.u_regs.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_regs.cycle_q;
    access(MMIO, 32'd0, 1'b0, q);
    checks++; if (q !== 32'hFFFF_FFFF) begin failures++; $display("FAIL cycle_max got=%h exp=ffffffff", q); end
    access(MMIO, 32'd0, 1'b0, q);
    checks++; if (q !== 32'd0) begin failures++; $display("FAIL cycle_wrap got=%h exp=0", q); end
  endtask

  task automatic test_timer();
    logic [31:0] m;
    do_reset();
    access(MMIO + 32'd2, 32'd20, 1'b1, q);
    while (cnt < 32'd20) access(32'd0, 32'd0, 1'b0, q);
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", timer_irq); end
    access(32'd0, 32'd0, 1'b0, q);
    checks++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL irq_edge21 got=%b exp=1", timer_irq); end
    access(32'd0, 32'd0, 1'b0, q);
    access(32'd0, 32'd0, 1'b0, q);
    checks++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL irq_hold got=%b exp=1", timer_irq); end
    access(MMIO + 32'd3, 32'h1, 1'b1, q);
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", timer_irq); end
    m = cnt + 32'd2;
    access(MMIO + 32'd2, m, 1'b1, q);
    access(32'd0, 32'd0, 1'b0, q);
    access(MMIO + 32'd3, 32'h1, 1'b1, q);
    checks++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL irq_set_wins got=%b exp=1", timer_irq); end
    access(MMIO + 32'd3, 32'h1, 1'b1, q);
    m = cnt + 32'd1;
    access(MMIO + 32'd2, m, 1'b1, q);
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL irq_preset got=%b exp=0", timer_irq); end
    access(MMIO + 32'd2, 32'hFFFF_0000, 1'b1, q);
    checks++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL irq_old_cmp got=%b exp=1", timer_irq); end
    access(MMIO + 32'd3, 32'd0, 1'b0, q);
    checks++; if (q !== 32'h1) begin failures++; $display("FAIL status_rd got=%h exp=1", q); end
    access(MMIO + 32'd2, 32'd0, 1'b0, q);
    checks++; if (q !== 32'hFFFF_0000) begin failures++; $display("FAIL cmp_rd got=%h exp=ffff0000", q); end
  endtask

  task automatic test_unmapped();
    access(32'd3, 32'h3333_3333, 1'b1, q);
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL berr_idle got=%b exp=0", bus_err); end
    access(32'(DEPTH + 3), 32'd0, 1'b0, q);
    checks++; if (q !== 32'd0) begin failures++; $display("FAIL unmap_rd got=%h exp=0", q); end
    checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL berr_set got=%b exp=1", bus_err); end
    access(32'd0, 32'd0, 1'b0, q);
    checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL berr_sticky got=%b exp=1", bus_err); end
    access(32'(DEPTH + 3), 32'h7777_7777, 1'b1, q);
    access(32'd3, 32'd0, 1'b0, q);
    checks++; if (q !== 32'h3333_3333) begin failures++; $display("FAIL unmap_wr got=%h exp=33333333", q); end
    access(MMIO + 32'd3, 32'd0, 1'b0, q);
    checks++; if (q[1] !== 1'b1) begin failures++; $display("FAIL status_berr got=%b exp=1", q[1]); end
    access(MMIO + 32'd3, 32'h2, 1'b1, q);
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL berr_clear got=%b exp=0", bus_err); end
    access(MMIO - 32'd1, 32'd0, 1'b0, q);
    checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL berr_below_mmio got=%b exp=1", bus_err); end
    access(MMIO + 32'd3, 32'h2, 1'b1, q);
    access(32'(DEPTH), 32'd0, 1'b0, q);
    checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL berr_depth got=%b exp=1", bus_err); end
  endtask

  task automatic test_async_reset();
    access(MMIO + 32'd1, 32'h0000_ABCD, 1'b1, q);
    access(32'd7, 32'h0000_7777, 1'b1, q);
    access(MMIO + 32'd1, 32'd0, 1'b0, q);
    checks++; if (q !== 32'h0000_ABCD) begin failures++; $display("FAIL pre_rst_led got=%h exp=abcd", q); end
    bus.address_dmem = 32'd7;
    bus.data         = 32'h0000_DEAD;
    bus.wren         = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.q_dmem !== 32'd0) begin failures++; $display("FAIL arst_q got=%h exp=0", bus.q_dmem); end
    checks++; if (leds !== 16'd0) begin failures++; $display("FAIL arst_leds got=%h exp=0", leds); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL arst_berr got=%b exp=0", bus_err); end
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL arst_irq got=%b exp=0", timer_irq); end
    @(negedge clock);
    bus.wren = 1'b0;
    reset_n  = 1'b1;
    cnt      = 32'd0;
    access(MMIO + 32'd1, 32'd0, 1'b0, q);
    checks++; if (q !== 32'd0) begin failures++; $display("FAIL arst_led_rd got=%h exp=0", q); end
    access(32'd7, 32'd0, 1'b0, q);
    checks++; if (q !== 32'h0000_7777) begin failures++; $display("FAIL arst_drop_wr got=%h exp=7777", q); end
    access(MMIO, 32'd0, 1'b0, q);
    checks++; if (q !== 32'd2) begin failures++; $display("FAIL arst_cycle got=%h exp=2", q); end
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.address_dmem = 32'd0;
    bus.data         = 32'd0;
    bus.wren         = 1'b0;
    test_reset();
    test_ram();
    test_rdw();
    test_led();
    test_cycle();
    test_timer();
    test_unmapped();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
